// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin burst arbiter in front of the SPI TX FIFO write port
// Optional burst watchdog: define SPI_TX_ARB_TIMEOUT_EN to add TIMEOUT_FLAG / TIMEOUT_CLR.
module spi_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [2*NUM_REQ-1:0]          BURST_LEN,
    input  logic [NUM_REQ-1:0]            VALID,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] WDATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic                          READY,
    input  logic                          FIFO_FULL,
    output logic                          FIFO_WRITE,
    output logic [DATA_WIDTH-1:0]         FIFO_DATA,
`ifdef SPI_TX_ARB_TIMEOUT_EN
    output logic                          TIMEOUT_FLAG,
    input  logic                          TIMEOUT_CLR,
`endif
    output logic                          BUSY
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("spi_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [1:0]      cnt;

    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [1:0]            len_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign wdata_arr[i] = WDATA[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i];
        assign len_arr[i]   = BURST_LEN[2*i+1 : 2*i];
    end

    // Scan from last+1 upward; iterating downward lets the nearest candidate win.
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          any_req;

    always_comb begin
        win     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(last) + 1 + k) % NUM_REQ);
            if (REQ[cand]) begin
                win     = cand;
                any_req = 1'b1;
            end
        end
    end

    logic in_burst;
    logic beat;

    assign in_burst   = (state == BURST);
    assign READY      = in_burst && !FIFO_FULL;
    assign beat       = READY && VALID[owner];
    assign FIFO_WRITE = beat;
    assign FIFO_DATA  = in_burst ? wdata_arr[owner] : '0;

    logic timeout_hit;

`ifdef SPI_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_idle;

    // Only cycles where the FIFO could have taken a word count as idle.
    assign wd_idle     = in_burst && !VALID[owner] && !FIFO_FULL;
    assign timeout_hit = wd_idle && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wd_cnt       <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            if (!in_burst || beat || timeout_hit)
                wd_cnt <= '0;
            else if (wd_idle)
                wd_cnt <= wd_cnt + 1'b1;

            if (timeout_hit)
                TIMEOUT_FLAG <= 1'b1;
            else if (TIMEOUT_CLR)
                TIMEOUT_FLAG <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
            cnt   <= 2'd0;
            owner <= '0;
            last  <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        GNT   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                        BUSY  <= 1'b1;
                        cnt   <= len_arr[win];
                        owner <= win;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // Abort (REQ drop or watchdog) and last beat share the same exit.
                    if (!REQ[owner] || timeout_hit || (beat && cnt == 2'd0)) begin
                        GNT   <= '0;
                        BUSY  <= 1'b0;
                        cnt   <= 2'd0;
                        last  <= owner;
                        state <= IDLE;
                    end else if (beat) begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - directed self-checking bench for spi_tx_arbiter
module tb_spi_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [N-1:0]    REQ;
    logic [2*N-1:0]  BURST_LEN;
    logic [N-1:0]    VALID;
    logic [DW*N-1:0] WDATA;
    logic [N-1:0]    GNT;
    logic            READY;
    logic            FIFO_FULL;
    logic            FIFO_WRITE;
    logic [DW-1:0]   FIFO_DATA;
    logic            BUSY;
`ifdef SPI_TX_ARB_TIMEOUT_EN
    logic            TIMEOUT_FLAG;
    logic            TIMEOUT_CLR;
`endif

    int checks = 0;
    int errors = 0;
    int writes;

    always #5 CLK = ~CLK;

    spi_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ        (REQ),
        .BURST_LEN  (BURST_LEN),
        .VALID      (VALID),
        .WDATA      (WDATA),
        .GNT        (GNT),
        .READY      (READY),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRITE (FIFO_WRITE),
        .FIFO_DATA  (FIFO_DATA),
`ifdef SPI_TX_ARB_TIMEOUT_EN
        .TIMEOUT_FLAG (TIMEOUT_FLAG),
        .TIMEOUT_CLR  (TIMEOUT_CLR),
`endif
        .BUSY       (BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0; REQ = '0; BURST_LEN = '0; VALID = '0; WDATA = '0; FIFO_FULL = 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
        TIMEOUT_CLR = 1'b0;
`endif
        tick();
        tick();
        settle();
        chk("rst_gnt",   GNT, 4'b0000);
        chk("rst_busy",  BUSY, 1'b0);
        chk("rst_ready", READY, 1'b0);
        chk("rst_write", FIFO_WRITE, 1'b0);
        chk("rst_data",  FIFO_DATA, 32'h0);

        // Single requester, 4-word burst
        tick();
        RST_N = 1'b1;
        REQ = 4'b0001; BURST_LEN = 8'h03; VALID = 4'b0001; WDATA[31:0] = 32'hA0;
        settle();
        chk("t1_latency_gnt", GNT, 4'b0000);
        for (int b = 0; b < 4; b++) begin
            tick();
            WDATA[31:0] = 32'hA0 + 32'(b);
            settle();
            chk("t1_gnt",   GNT, 4'b0001);
            chk("t1_busy",  BUSY, 1'b1);
            chk("t1_write", FIFO_WRITE, 1'b1);
            chk("t1_data",  FIFO_DATA, 32'hA0 + 32'(b));
        end
        tick();
        REQ = 4'b0000;
        settle();
        chk("t1_end_gnt",   GNT, 4'b0000);
        chk("t1_end_busy",  BUSY, 1'b0);
        chk("t1_end_write", FIFO_WRITE, 1'b0);
        chk("t1_end_data",  FIFO_DATA, 32'h0);

        // All requesting, single-beat bursts: order 0,1,2,3,0 with an IDLE between
        do_reset();
        REQ = 4'b1111; BURST_LEN = 8'h00; VALID = 4'b1111;
        WDATA = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        for (int g = 0; g < 5; g++) begin
            tick();
            settle();
            chk("t2_gnt",   GNT, 4'b0001 << (g % 4));
            chk("t2_data",  FIFO_DATA, 32'hB0 + 32'(g % 4));
            chk("t2_write", FIFO_WRITE, 1'b1);
            tick();
            if (g == 4) REQ = 4'b0000;
            settle();
            chk("t2_gap_gnt",  GNT, 4'b0000);
            chk("t2_gap_busy", BUSY, 1'b0);
        end

        // Requester 2, 2-word burst, stalled by FIFO_FULL; foreign VALID ignored
        REQ = 4'b0100; BURST_LEN = 8'h10; VALID = 4'b0100;
        WDATA = {32'hD3, 32'hC0, 32'hD1, 32'hD0};
        tick();
        settle();
        chk("t3_gnt",    GNT, 4'b0100);
        chk("t3_data0",  FIFO_DATA, 32'hC0);
        chk("t3_write0", FIFO_WRITE, 1'b1);
        for (int s = 0; s < 5; s++) begin
            tick();
            FIFO_FULL = 1'b1; VALID = 4'b0101; WDATA[95:64] = 32'hC1;
            settle();
            chk("t3_stall_ready", READY, 1'b0);
            chk("t3_stall_write", FIFO_WRITE, 1'b0);
            chk("t3_stall_gnt",   GNT, 4'b0100);
        end
        tick();
        FIFO_FULL = 1'b0;
        settle();
        chk("t3_ready1", READY, 1'b1);
        chk("t3_write1", FIFO_WRITE, 1'b1);
        chk("t3_data1",  FIFO_DATA, 32'hC1);
        tick();
        REQ = 4'b0000; VALID = 4'b0000;
        settle();
        chk("t3_end_gnt",  GNT, 4'b0000);
        chk("t3_end_busy", BUSY, 1'b0);

        // Requester 1, 4-word burst aborted by REQ drop after two beats
        REQ = 4'b0010; BURST_LEN = 8'h0C; VALID = 4'b0010;
        writes = 0;
        for (int b = 0; b < 2; b++) begin
            tick();
            settle();
            chk("t4_gnt", GNT, 4'b0010);
            if (FIFO_WRITE) writes++;
        end
        tick();
        REQ = 4'b0000; VALID = 4'b0000;
        settle();
        if (FIFO_WRITE) writes++;
        chk("t4_writes", 64'(writes), 64'd2);
        tick();
        REQ = 4'b0111;
        settle();
        chk("t4_abort_gnt",  GNT, 4'b0000);
        chk("t4_abort_busy", BUSY, 1'b0);
        tick();
        REQ = 4'b0000;
        settle();
        chk("t4_next_gnt", GNT, 4'b0100);
        tick();
        settle();
        chk("t4_idle_gnt", GNT, 4'b0000);

        // Reset in the middle of a 4-word burst from requester 3
        REQ = 4'b1000; BURST_LEN = 8'hC0; VALID = 4'b1000;
        tick();
        settle();
        chk("t5_gnt", GNT, 4'b1000);
        tick();
        RST_N = 1'b0;
        settle();
        chk("t5_beat2_write", FIFO_WRITE, 1'b1);
        tick();
        REQ = 4'b1001;
        settle();
        chk("t5_rst_gnt",   GNT, 4'b0000);
        chk("t5_rst_busy",  BUSY, 1'b0);
        chk("t5_rst_write", FIFO_WRITE, 1'b0);
        chk("t5_rst_data",  FIFO_DATA, 32'h0);
        tick();
        RST_N = 1'b1;
        tick();
        REQ = 4'b0000;
        settle();
        chk("t5_post_gnt", GNT, 4'b0001);
        tick();
        settle();
        chk("t5_post_idle", GNT, 4'b0000);

`ifdef SPI_TX_ARB_TIMEOUT_EN
        // Watchdog: 16 idle beats abort; FIFO_FULL stalls never time out
        do_reset();
        REQ = 4'b0001; BURST_LEN = 8'h00; VALID = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            settle();
            chk("t6_hold_gnt",  GNT, 4'b0001);
            chk("t6_hold_flag", TIMEOUT_FLAG, 1'b0);
        end
        tick();
        REQ = 4'b0000;
        settle();
        chk("t6_abort_gnt", GNT, 4'b0000);
        chk("t6_flag_set",  TIMEOUT_FLAG, 1'b1);
        tick();
        TIMEOUT_CLR = 1'b1;
        settle();
        chk("t6_flag_sticky", TIMEOUT_FLAG, 1'b1);
        tick();
        TIMEOUT_CLR = 1'b0;
        FIFO_FULL = 1'b1; REQ = 4'b0001;
        settle();
        chk("t6_flag_clr", TIMEOUT_FLAG, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tick();
            settle();
            chk("t6_full_gnt",  GNT, 4'b0001);
            chk("t6_full_flag", TIMEOUT_FLAG, 1'b0);
        end
        REQ = 4'b0000; FIFO_FULL = 1'b0;
        tick();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
